// File: rtl/tt_um_marxkar_seqdetc_param_if.sv
// rtl/tt_um_marxkar_seqdetc_param_if.sv - serial-bit, config and status bundle for the sequence detector
interface tt_um_marxkar_seqdetc_param_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  localparam int W = $clog2(N + 1);

  logic             ena;
  logic             input_bit;
  logic             cfg_load;
  logic [N-1:0]     cfg_pattern;
  logic             cfg_overlap;
  logic             cnt_clear;
  logic             output_indicator;
  logic [W-1:0]     present_state;
  logic [CNT_W-1:0] match_count;

  modport master (
    output ena, input_bit, cfg_load, cfg_pattern, cfg_overlap, cnt_clear,
    input  output_indicator, present_state, match_count
  );

  modport slave (
    input  ena, input_bit, cfg_load, cfg_pattern, cfg_overlap, cnt_clear,
    output output_indicator, present_state, match_count
  );
endinterface

// File: rtl/tt_um_marxkar_seqdetc_param.sv
// rtl/tt_um_marxkar_seqdetc_param.sv - parametrised serial sequence detector with progress and match counter
module tt_um_marxkar_seqdetc_param #(
  parameter int           N           = 4,
  parameter logic [N-1:0] PATTERN_RST = 4'b1010,
  parameter logic         OVERLAP_RST = 1'b1,
  parameter int           CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  tt_um_marxkar_seqdetc_param_if.slave bus
);
  localparam int           W    = $clog2(N + 1);
  localparam logic [N-1:0] ONES = '1;

  logic [N-1:0]     pat_q, pat_d;
  logic             ovl_q, ovl_d;
  logic [N-1:0]     hist_q, hist_d;
  logic [W-1:0]     fill_q, fill_d;
  logic [W-1:0]     ps_q, ps_d;
  logic             oi_q, oi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0]     hist_sh;
  logic [W-1:0]     fill_sh;
  logic [W-1:0]     prog;
  logic             hit;
  logic             match_evt;

  // State register: all detector state, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= PATTERN_RST;
      ovl_q  <= OVERLAP_RST;
      hist_q <= '0;
      fill_q <= '0;
      ps_q   <= '0;
      oi_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      ps_q   <= ps_d;
      oi_q   <= oi_d;
      cnt_q  <= cnt_d;
    end
  end

  // Next state: shift in the bit, find the longest pattern prefix ending the history
  always_comb begin
    hist_sh = {hist_q[N-2:0], bus.input_bit};
    fill_sh = (fill_q == W'(N)) ? fill_q : fill_q + W'(1);
    hit     = (fill_sh == W'(N)) && (hist_sh == pat_q);

    // Only the newest fill bits are real history; older positions are ignored
    prog = '0;
    for (int k = 1; k <= N; k++) begin
      if ((int'(fill_sh) >= k) &&
          ((hist_sh & (ONES >> (N - k))) == (pat_q >> (N - k)))) begin
        prog = W'(k);
      end
    end

    pat_d  = pat_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    ps_d   = ps_q;
    oi_d   = 1'b0;

    if (bus.cfg_load) begin
      pat_d  = bus.cfg_pattern;
      ovl_d  = bus.cfg_overlap;
      hist_d = '0;
      fill_d = '0;
      ps_d   = '0;
    end else if (bus.ena) begin
      hist_d = hist_sh;
      // Non-overlap restarts from empty history; the match cycle still shows N
      fill_d = (hit && !ovl_q) ? '0 : fill_sh;
      ps_d   = prog;
      oi_d   = hit;
    end else if (fill_q == '0) begin
      // Idle edge after a non-overlap match retires the N progress value
      ps_d   = '0;
    end

    match_evt = !bus.cfg_load && bus.ena && hit;

    cnt_d = cnt_q;
    if (bus.cnt_clear) begin
      cnt_d = match_evt ? CNT_W'(1) : '0;
    end else if (match_evt && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs: straight from registers
  always_comb begin
    bus.output_indicator = oi_q;
    bus.present_state    = ps_q;
    bus.match_count      = cnt_q;
  end
endmodule

// File: tb/tb_tt_um_marxkar_seqdetc_param.sv
// tb/tb_tt_um_marxkar_seqdetc_param.sv - directed self-checking bench for the sequence detector
module tb_tt_um_marxkar_seqdetc_param;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  tt_um_marxkar_seqdetc_param_if #(.N(4), .CNT_W(8)) bus_a ();
  tt_um_marxkar_seqdetc_param_if #(.N(4), .CNT_W(2)) bus_b ();

  tt_um_marxkar_seqdetc_param #(.N(4), .PATTERN_RST(4'b1010), .OVERLAP_RST(1'b1), .CNT_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  tt_um_marxkar_seqdetc_param #(.N(4), .PATTERN_RST(4'b1010), .OVERLAP_RST(1'b1), .CNT_W(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  assign bus_b.ena         = bus_a.ena;
  assign bus_b.input_bit   = bus_a.input_bit;
  assign bus_b.cfg_load    = bus_a.cfg_load;
  assign bus_b.cfg_pattern = bus_a.cfg_pattern;
  assign bus_b.cfg_overlap = bus_a.cfg_overlap;
  assign bus_b.cnt_clear   = bus_a.cnt_clear;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic e);
    bus_a.input_bit = b;
    bus_a.ena       = e;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag, input logic oi, input int ps);
    chk({tag, "_oi"}, 32'(bus_a.output_indicator), 32'(oi));
    chk({tag, "_ps"}, 32'(bus_a.present_state), 32'(ps));
  endtask

  task automatic load(input logic [3:0] p, input logic o);
    bus_a.cfg_load    = 1'b1;
    bus_a.cfg_pattern = p;
    bus_a.cfg_overlap = o;
    step(1'b1, 1'b1);
    bus_a.cfg_load    = 1'b0;
    expect_a("load", 1'b0, 0);
  endtask

  initial begin
    logic [6:0] s1_bits;
    logic [6:0] s1_oi;
    int         s1_ps[7];
    logic [7:0] s2_oi;
    int         s2_ps[8];
    logic [3:0] s5_bits;
    int         s5_ps[4];

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_a.ena = 1'b0;
    bus_a.input_bit = 1'b0;
    bus_a.cfg_load = 1'b0;
    bus_a.cfg_pattern = 4'b0000;
    bus_a.cfg_overlap = 1'b0;
    bus_a.cnt_clear = 1'b0;

    // Reset state
    #1;
    expect_a("rst", 1'b0, 0);
    chk("rst_cnt", 32'(bus_a.match_count), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Overlapping 1010 in 1010101
    s1_bits = 7'b1010101;
    s1_oi   = 7'b0001010;
    s1_ps   = '{1, 2, 3, 4, 3, 4, 3};
    for (int i = 0; i < 7; i++) begin
      step(s1_bits[6-i], 1'b1);
      expect_a($sformatf("ovl_b%0d", i + 1), s1_oi[6-i], s1_ps[i]);
    end
    chk("ovl_cnt", 32'(bus_a.match_count), 2);

    // Non-overlap mode: 10101010 matches only at bits 4 and 8
    load(4'b1010, 1'b0);
    chk("load_cnt_kept", 32'(bus_a.match_count), 2);
    s2_oi = 8'b00010001;
    s2_ps = '{1, 2, 3, 4, 1, 2, 3, 4};
    for (int i = 0; i < 8; i++) begin
      step(i[0] ? 1'b0 : 1'b1, 1'b1);
      expect_a($sformatf("novl_b%0d", i + 1), s2_oi[7-i], s2_ps[i]);
    end
    chk("novl_cnt", 32'(bus_a.match_count), 4);

    // ena gap holds progress, input ignored
    load(4'b1010, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    expect_a("gap_pre", 1'b0, 3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      expect_a($sformatf("gap_%0d", i), 1'b0, 3);
    end
    step(1'b0, 1'b1);
    expect_a("gap_done", 1'b1, 4);
    chk("gap_cnt", 32'(bus_a.match_count), 5);

    // Asynchronous reset mid-cycle discards the partial match
    load(4'b1010, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    expect_a("arst_pre", 1'b0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    expect_a("arst_now", 1'b0, 0);
    chk("arst_cnt", 32'(bus_a.match_count), 0);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b1);
    expect_a("arst_after", 1'b0, 0);

    // Reload to 1101 after 110: stale bits never match
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    expect_a("pre110", 1'b0, 2);
    load(4'b1101, 1'b1);
    s5_bits = 4'b1101;
    s5_ps   = '{1, 2, 3, 4};
    for (int i = 0; i < 4; i++) begin
      step(s5_bits[3-i], 1'b1);
      expect_a($sformatf("p1101_b%0d", i + 1), (i == 3), s5_ps[i]);
    end
    chk("p1101_cnt", 32'(bus_a.match_count), 1);
    chk("p1101_cnt_b", 32'(bus_b.match_count), 1);

    // Saturation on the 2-bit counter: four more matches
    load(4'b1010, 1'b1);
    for (int i = 0; i < 10; i++) step(i[0] ? 1'b0 : 1'b1, 1'b1);
    expect_a("sat_last", 1'b1, 4);
    chk("sat_cnt_a", 32'(bus_a.match_count), 5);
    chk("sat_cnt_b", 32'(bus_b.match_count), 3);

    // Clear coinciding with a match leaves a count of one
    step(1'b1, 1'b1);
    bus_a.cnt_clear = 1'b1;
    step(1'b0, 1'b1);
    bus_a.cnt_clear = 1'b0;
    expect_a("clr_match", 1'b1, 4);
    chk("clr_cnt_a", 32'(bus_a.match_count), 1);
    chk("clr_cnt_b", 32'(bus_b.match_count), 1);

    // Plain clear with no activity
    bus_a.cnt_clear = 1'b1;
    step(1'b0, 1'b0);
    bus_a.cnt_clear = 1'b0;
    chk("clr_idle", 32'(bus_a.match_count), 0);
    expect_a("clr_idle", 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
